if_predec_buf: RTL and testbench

IF_PREDEC_BUF -- requirements
Module: if_predec_buf

---
 rtl/if_predec_buf_pkg.sv | 48 ++++
 rtl/if_predec_buf_dec.sv | 95 +++++++++
 rtl/if_predec_buf.sv | 138 +++++++++++++
 tb/tb_if_predec_buf.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_predec_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_predec_buf_pkg
// Brief   : Shared opcode/funct constants, width defaults and mul/div classes
// Revision: 1.0
// ============================================================================
package if_predec_buf_pkg;

    localparam int c_ir_size    = 32;
    localparam int c_pc_size    = 32;
    localparam int c_rfidx_w    = 5;

    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_bxx    = 7'b1100011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;

    localparam logic [6:0] c_f7_muldiv  = 7'b0000001;

    localparam logic [2:0] c_f3_jalr    = 3'b000;
    localparam logic [2:0] c_f3_mul     = 3'b000;
    localparam logic [2:0] c_f3_mulh    = 3'b001;
    localparam logic [2:0] c_f3_mulhsu  = 3'b010;
    localparam logic [2:0] c_f3_mulhu   = 3'b011;
    localparam logic [2:0] c_f3_div     = 3'b100;
    localparam logic [2:0] c_f3_divu    = 3'b101;
    localparam logic [2:0] c_f3_rem     = 3'b110;
    localparam logic [2:0] c_f3_remu    = 3'b111;

    // MULH covers all three high-half variants: any of them may fuse with MUL.
    typedef enum logic [2:0] {
        MD_NONE = 3'd0,
        MD_MULH = 3'd1,
        MD_MUL  = 3'd2,
        MD_DIV  = 3'd3,
        MD_REM  = 3'd4,
        MD_DIVU = 3'd5,
        MD_REMU = 3'd6
    } md_class_e;

    function automatic logic md_pair(input md_class_e prev, input md_class_e cur);
        return ((prev == MD_MULH) && (cur == MD_MUL)) ||
               ((prev == MD_DIV)  && (cur == MD_REM)) ||
               ((prev == MD_DIVU) && (cur == MD_REMU));
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_predec_buf_dec.sv
`default_nettype none
// ============================================================================
// Module  : if_predec_dec
// Brief   : Combinational predecoder: branch flags, static prediction, indices
// Revision: 1.0
// ============================================================================
module if_predec_dec
    import if_predec_buf_pkg::*;
#(
    parameter int PC_SIZE = c_pc_size,
    parameter int RFIDX_W = c_rfidx_w
) (
    input  logic [c_ir_size-1:0] instr,
    input  logic [PC_SIZE-1:0]   pc,
    output logic                 rv32,
    output logic                 jal,
    output logic                 jalr,
    output logic                 bxx,
    output logic                 prdt_taken,
    output logic [PC_SIZE-1:0]   prdt_tgt,
    output logic [RFIDX_W-1:0]   rs1idx,
    output logic [RFIDX_W-1:0]   rs2idx,
    output logic [4:0]           rs1_fld,
    output logic [4:0]           rs2_fld,
    output logic [4:0]           rd_fld,
    output md_class_e            md_class
);

    logic [6:0]         w_opc;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [31:0]        w_imm_j;
    logic [31:0]        w_imm_b;
    logic [31:0]        w_imm_i;
    logic [PC_SIZE-1:0] w_pc_plus2;
    logic [PC_SIZE-1:0] w_pc_plus4;

    assign w_opc   = instr[6:0];
    assign w_f3    = instr[14:12];
    assign w_f7    = instr[31:25];
    assign rs1_fld = instr[19:15];
    assign rs2_fld = instr[24:20];
    assign rd_fld  = instr[11:7];

    assign w_imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign w_imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_i = {{21{instr[31]}}, instr[30:20]};

    assign w_pc_plus2 = pc + PC_SIZE'(2);
    assign w_pc_plus4 = pc + PC_SIZE'(4);

    assign rv32 = (instr[1:0] == 2'b11);
    assign jal  = rv32 && (w_opc == c_opc_jal);
    assign jalr = rv32 && (w_opc == c_opc_jalr) && (w_f3 == c_f3_jalr);
    assign bxx  = rv32 && (w_opc == c_opc_bxx);

    assign rs1idx = rv32 ? RFIDX_W'(rs1_fld) : '0;
    assign rs2idx = rv32 ? RFIDX_W'(rs2_fld) : '0;

    always_comb begin
        prdt_taken = 1'b0;
        prdt_tgt   = rv32 ? w_pc_plus4 : w_pc_plus2;
        if (jal) begin
            prdt_taken = 1'b1;
            prdt_tgt   = pc + PC_SIZE'($signed(w_imm_j));
        end else if (jalr) begin
            // Only x0-based jalr is resolvable here; others wait for rs1 downstream.
            prdt_taken = 1'b1;
            prdt_tgt   = (rs1_fld == 5'd0) ?
                         (PC_SIZE'($signed(w_imm_i)) & ~PC_SIZE'(1)) : '0;
        end else if (bxx) begin
            prdt_taken = w_imm_b[31];
            prdt_tgt   = w_imm_b[31] ? (pc + PC_SIZE'($signed(w_imm_b))) : w_pc_plus4;
        end
    end

    always_comb begin
        md_class = MD_NONE;
        if (rv32 && (w_opc == c_opc_op) && (w_f7 == c_f7_muldiv)) begin
            case (w_f3)
                c_f3_mul:    md_class = MD_MUL;
                c_f3_mulh,
                c_f3_mulhsu,
                c_f3_mulhu:  md_class = MD_MULH;
                c_f3_div:    md_class = MD_DIV;
                c_f3_divu:   md_class = MD_DIVU;
                c_f3_rem:    md_class = MD_REM;
                c_f3_remu:   md_class = MD_REMU;
                default:     md_class = MD_NONE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_predec_buf.sv
`default_nettype none
// ============================================================================
// Module  : if_predec_buf
// Brief   : Instruction FIFO that predecodes at enqueue and tracks mul/div fusion
// Revision: 1.0
// ============================================================================
module if_predec_buf
    import if_predec_buf_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_SIZE = c_pc_size,
    parameter int RFIDX_W = c_rfidx_w
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_SIZE-1:0]       in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [PC_SIZE-1:0]       out_pc,
    output logic                     out_rv32,
    output logic                     out_jal,
    output logic                     out_jalr,
    output logic                     out_bxx,
    output logic                     out_prdt_taken,
    output logic                     out_muldiv_b2b,
    output logic [PC_SIZE-1:0]       out_prdt_tgt,
    output logic [RFIDX_W-1:0]       out_rs1idx,
    output logic [RFIDX_W-1:0]       out_rs2idx,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic                 w_rv32, w_jal, w_jalr, w_bxx, w_taken, w_b2b;
    logic [PC_SIZE-1:0]   w_tgt;
    logic [RFIDX_W-1:0]   w_rs1idx, w_rs2idx;
    logic [4:0]           w_rs1_fld, w_rs2_fld, w_rd_fld;
    md_class_e            w_md_class;

    logic [31:0]          r_instr [DEPTH];
    logic [PC_SIZE-1:0]   r_pc    [DEPTH];
    logic [PC_SIZE-1:0]   r_tgt   [DEPTH];
    logic [RFIDX_W-1:0]   r_rs1   [DEPTH];
    logic [RFIDX_W-1:0]   r_rs2   [DEPTH];
    logic [5:0]           r_flags [DEPTH];

    logic [c_aw:0]        r_wr_ptr, r_rd_ptr;
    logic                 r_h_valid;
    md_class_e            r_h_cls;
    logic [4:0]           r_h_rs1, r_h_rs2, r_h_rd;

    logic                 w_full, w_empty, w_push, w_pop;
    logic [c_aw-1:0]      w_wr_idx, w_rd_idx;

    if_predec_dec #(
        .PC_SIZE (PC_SIZE),
        .RFIDX_W (RFIDX_W)
    ) u_dec (
        .instr      (in_instr),
        .pc         (in_pc),
        .rv32       (w_rv32),
        .jal        (w_jal),
        .jalr       (w_jalr),
        .bxx        (w_bxx),
        .prdt_taken (w_taken),
        .prdt_tgt   (w_tgt),
        .rs1idx     (w_rs1idx),
        .rs2idx     (w_rs2idx),
        .rs1_fld    (w_rs1_fld),
        .rs2_fld    (w_rs2_fld),
        .rd_fld     (w_rd_fld),
        .md_class   (w_md_class)
    );

    assign w_wr_idx  = r_wr_ptr[c_aw-1:0];
    assign w_rd_idx  = r_rd_ptr[c_aw-1:0];
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
    assign in_ready  = !w_full && !flush;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_count = r_wr_ptr - r_rd_ptr;

    // Fusion needs matching sources and a result that does not clobber them.
    assign w_b2b = w_rv32 && r_h_valid && md_pair(r_h_cls, w_md_class) &&
                   (r_h_rs1 == w_rs1_fld) && (r_h_rs2 == w_rs2_fld) &&
                   (r_h_rd != r_h_rs1) && (r_h_rd != r_h_rs2) && (r_h_rd == w_rd_fld);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[w_wr_idx] <= in_instr;
            r_pc[w_wr_idx]    <= in_pc;
            r_tgt[w_wr_idx]   <= w_tgt;
            r_rs1[w_wr_idx]   <= w_rs1idx;
            r_rs2[w_wr_idx]   <= w_rs2idx;
            r_flags[w_wr_idx] <= {w_rv32, w_jal, w_jalr, w_bxx, w_taken, w_b2b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_h_valid <= 1'b0;
            r_h_cls   <= MD_NONE;
            r_h_rs1   <= '0;
            r_h_rs2   <= '0;
            r_h_rd    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_h_valid <= w_rv32;
                r_h_cls   <= w_md_class;
                r_h_rs1   <= w_rs1_fld;
                r_h_rs2   <= w_rs2_fld;
                r_h_rd    <= w_rd_fld;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign out_instr      = r_instr[w_rd_idx];
    assign out_pc         = r_pc[w_rd_idx];
    assign out_prdt_tgt   = r_tgt[w_rd_idx];
    assign out_rs1idx     = r_rs1[w_rd_idx];
    assign out_rs2idx     = r_rs2[w_rd_idx];
    assign {out_rv32, out_jal, out_jalr, out_bxx, out_prdt_taken, out_muldiv_b2b} = r_flags[w_rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_if_predec_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_predec_buf
// Brief   : Directed and randomized self-checking bench for if_predec_buf
// Revision: 1.0
// ============================================================================
module tb_if_predec_buf;

    localparam int DEPTH   = 4;
    localparam int PC_SIZE = 32;
    localparam int RFIDX_W = 5;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc, out_prdt_tgt;
    logic        out_rv32, out_jal, out_jalr, out_bxx, out_prdt_taken, out_muldiv_b2b;
    logic [4:0]  out_rs1idx, out_rs2idx;
    logic [2:0]  out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_predec_buf #(.DEPTH(DEPTH), .PC_SIZE(PC_SIZE), .RFIDX_W(RFIDX_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_rv32(out_rv32), .out_jal(out_jal), .out_jalr(out_jalr), .out_bxx(out_bxx),
        .out_prdt_taken(out_prdt_taken), .out_muldiv_b2b(out_muldiv_b2b),
        .out_prdt_tgt(out_prdt_tgt), .out_rs1idx(out_rs1idx), .out_rs2idx(out_rs2idx),
        .out_count(out_count)
    );

    // Reference model: queue of decoded entries plus the previous rv32 push.
    typedef struct {
        logic [31:0] instr, pc, tgt;
        logic        rv32, jal, jalr, bxx, taken, b2b;
        logic [4:0]  rs1, rs2;
    } ent_t;

    ent_t       exp_q[$];
    bit         m_hv, m_md;
    int         m_f3;
    logic [4:0] m_rs1, m_rs2, m_rd;

    function automatic ent_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
        ent_t e;
        int   imm, f3;
        bit   cur_md, pair;
        e = '{instr: instr, pc: pc, tgt: pc + 32'd2, rv32: 0, jal: 0, jalr: 0,
              bxx: 0, taken: 0, b2b: 0, rs1: 5'd0, rs2: 5'd0};
        if (instr[1:0] != 2'b11) return e;
        f3     = int'(instr[14:12]);
        e.rv32 = 1;
        e.rs1  = instr[19:15];
        e.rs2  = instr[24:20];
        e.tgt  = pc + 32'd4;
        case (instr[6:0])
            7'h6F: begin
                imm = (instr[31] ? -(1 << 20) : 0) + (int'(instr[19:12]) << 12)
                    + (int'(instr[20]) << 11) + (int'(instr[30:21]) << 1);
                e.jal = 1; e.taken = 1; e.tgt = pc + 32'(imm);
            end
            7'h67: if (f3 == 0) begin
                imm = (instr[31] ? -2048 : 0) + int'(instr[30:20]);
                e.jalr = 1; e.taken = 1;
                e.tgt  = (e.rs1 == 0) ? 32'(imm & -2) : 32'd0;
            end
            7'h63: begin
                imm = (instr[31] ? -4096 : 0) + (int'(instr[7]) << 11)
                    + (int'(instr[30:25]) << 5) + (int'(instr[11:8]) << 1);
                e.bxx = 1;
                if (imm < 0) begin e.taken = 1; e.tgt = pc + 32'(imm); end
            end
            default: ;
        endcase
        cur_md = (instr[6:0] == 7'h33) && (instr[31:25] == 7'h01);
        pair   = (m_f3 >= 1 && m_f3 <= 3 && f3 == 0) || (m_f3 == 4 && f3 == 6) ||
                 (m_f3 == 5 && f3 == 7);
        e.b2b  = m_hv && m_md && cur_md && pair && (m_rs1 == e.rs1) && (m_rs2 == e.rs2) &&
                 (m_rd != m_rs1) && (m_rd != m_rs2) && (m_rd == instr[11:7]);
        return e;
    endfunction

    task automatic model_edge(input bit r, input bit f, input bit iv,
                              input logic [31:0] ii, input logic [31:0] ip, input bit ordy);
        bit   push, pop;
        ent_t e;
        if (r || f) begin
            exp_q.delete();
            m_hv = 0;
            return;
        end
        push = iv && (exp_q.size() < DEPTH);
        pop  = (exp_q.size() > 0) && ordy;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            e = ref_decode(ii, ip);
            exp_q.push_back(e);
            m_hv  = e.rv32;
            m_md  = (ii[6:0] == 7'h33) && (ii[31:25] == 7'h01);
            m_f3  = int'(ii[14:12]);
            m_rs1 = ii[19:15];
            m_rs2 = ii[24:20];
            m_rd  = ii[11:7];
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        x = $urandom();
        case ($urandom_range(0, 9))
            0: x[6:0] = 7'h6F;
            1: begin
                x[6:0] = 7'h67; x[14:12] = 3'd0;
                if ($urandom_range(0, 1) == 1) x[19:15] = 5'd0;
            end
            2, 3: x[6:0] = 7'h63;
            4, 5, 6: x = {7'h01, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 7'h33};
            7: x[1:0] = 2'($urandom_range(0, 2));
            default: x[1:0] = 2'b11;
        endcase
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
        step();
        step();
        rst = 0;
        exp_q.delete();
        m_hv = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1",
                     out_valid, out_count, in_ready);
        end
    endtask

    task automatic test_jal();
        do_reset();
        in_valid = 1; in_instr = 32'h0080006F; in_pc = 32'h80000000;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL jal_latency: out_valid=%b want 0", out_valid);
        end
        step();
        in_valid = 0;
        checks++;
        if ({out_valid, out_jal, out_prdt_taken, out_prdt_tgt} !== {1'b1, 1'b1, 1'b1, 32'h80000008}) begin
            errors++;
            $display("FAIL jal: got v=%b jal=%b tk=%b tgt=%h want 1 1 1 80000008",
                     out_valid, out_jal, out_prdt_taken, out_prdt_tgt);
        end
    endtask

    task automatic test_bxx();
        do_reset();
        in_valid = 1; in_instr = 32'hFE000EE3; in_pc = 32'h100;
        step();
        in_valid = 0;
        checks++;
        if ({out_bxx, out_prdt_taken, out_prdt_tgt} !== {1'b1, 1'b1, 32'hFC}) begin
            errors++;
            $display("FAIL bxx: got bxx=%b tk=%b tgt=%h want 1 1 000000fc",
                     out_bxx, out_prdt_taken, out_prdt_tgt);
        end
    endtask

    task automatic test_full();
        logic [31:0] ins [5];
        for (int i = 0; i < 5; i++) ins[i] = 32'h00000013 | (32'(i + 1) << 20);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_instr = ins[i]; in_pc = 32'(i * 4);
            step();
        end
        in_instr = ins[4]; in_pc = 32'd16;
        #1;
        checks++;
        if ({in_ready, out_count} !== {1'b0, 3'd4}) begin
            errors++; $display("FAIL full: got rdy=%b cnt=%0d want 0 4", in_ready, out_count);
        end
        step();
        checks++;
        if ({out_count, out_instr} !== {3'd4, ins[0]}) begin
            errors++; $display("FAIL full_hold: got cnt=%0d head=%h want 4 %h", out_count, out_instr, ins[0]);
        end
        out_ready = 1;
        step();
        checks++;
        if ({out_count, out_instr} !== {3'd3, ins[1]}) begin
            errors++; $display("FAIL full_drain: got cnt=%0d head=%h want 3 %h", out_count, out_instr, ins[1]);
        end
        step();
        in_valid = 0;
        checks++;
        if ({out_count, out_instr} !== {3'd3, ins[2]}) begin
            errors++; $display("FAIL push_pop: got cnt=%0d head=%h want 3 %h", out_count, out_instr, ins[2]);
        end
        for (int i = 3; i < 5; i++) begin
            step();
            checks++;
            if (out_instr !== ins[i]) begin
                errors++; $display("FAIL order%0d: got %h want %h", i, out_instr, ins[i]);
            end
        end
        out_ready = 0;
    endtask

    task automatic test_b2b();
        logic [31:0] second [2];
        logic        want [2];
        second[0] = 32'h02208233; want[0] = 1'b0;
        second[1] = 32'h022081B3; want[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            in_valid = 1; in_instr = 32'h022091B3; in_pc = 32'h200;
            step();
            in_instr = second[k]; in_pc = 32'h204;
            step();
            in_valid = 0; out_ready = 1;
            checks++;
            if (out_muldiv_b2b !== 1'b0) begin
                errors++; $display("FAIL b2b_first%0d: got %b want 0", k, out_muldiv_b2b);
            end
            step();
            out_ready = 0;
            checks++;
            if ({out_valid, out_muldiv_b2b} !== {1'b1, want[k]}) begin
                errors++; $display("FAIL b2b%0d: got v=%b b2b=%b want 1 %b", k, out_valid, out_muldiv_b2b, want[k]);
            end
        end
        do_reset();
        in_valid = 1; in_instr = 32'h022091B3;
        step();
        in_valid = 0; flush = 1;
        step();
        flush = 0; in_valid = 1; in_instr = 32'h022081B3;
        step();
        in_valid = 0;
        checks++;
        if ({out_valid, out_instr, out_muldiv_b2b} !== {1'b1, 32'h022081B3, 1'b0}) begin
            errors++; $display("FAIL b2b_flush: got v=%b ins=%h b2b=%b want 1 022081b3 0",
                               out_valid, out_instr, out_muldiv_b2b);
        end
    endtask

    task automatic test_flush_rst();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 3; i++) begin
                in_valid = 1; in_instr = 32'h00000013; in_pc = 32'(i * 4);
                step();
            end
            in_instr = 32'h0080006F;
            if (k == 0) flush = 1; else rst = 1;
            #1;
            if (k == 0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL flush_rdy: got %b want 0", in_ready);
                end
            end
            out_ready = 1;
            step();
            flush = 0; rst = 0; in_valid = 0; out_ready = 0;
            checks++;
            if ({out_valid, out_count} !== {1'b0, 3'd0}) begin
                errors++; $display("FAIL drop%0d: got v=%b cnt=%0d want 0 0", k, out_valid, out_count);
            end
            step();
            checks++;
            if ({out_valid, out_count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
                errors++; $display("FAIL drop_in%0d: got v=%b cnt=%0d rdy=%b want 0 0 1",
                                   k, out_valid, out_count, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [111:0] got, want;
        ent_t         e;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_instr  = rand_instr();
            in_pc     = $urandom() & 32'hFFFF_FFFE;
            #1;
            checks++;
            if (in_ready !== ((exp_q.size() < DEPTH) && !flush)) begin
                errors++; $display("FAIL rnd_rdy@%0d: got %b size=%0d flush=%b", cyc, in_ready, exp_q.size(), flush);
            end
            model_edge(rst, flush, in_valid, in_instr, in_pc, out_ready);
            step();
            checks++;
            if ({out_valid, out_count} !== {exp_q.size() > 0, 3'(exp_q.size())}) begin
                errors++; $display("FAIL rnd_cnt@%0d: got v=%b cnt=%0d want cnt=%0d", cyc, out_valid, out_count, exp_q.size());
            end
            if (exp_q.size() > 0) begin
                e    = exp_q[0];
                want = {e.instr, e.pc, e.rv32, e.jal, e.jalr, e.bxx, e.taken, e.b2b, e.tgt, e.rs1, e.rs2};
                got  = {out_instr, out_pc, out_rv32, out_jal, out_jalr, out_bxx, out_prdt_taken,
                        out_muldiv_b2b, out_prdt_tgt, out_rs1idx, out_rs2idx};
                checks++;
                if (got !== want) begin
                    errors++; $display("FAIL rnd_head@%0d: got %h want %h", cyc, got, want);
                end
            end
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
        test_reset();
        test_jal();
        test_bxx();
        test_full();
        test_b2b();
        test_flush_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
